// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: captures rising edges on NUM_SRC interrupt lines, masks them and
//   hands one winner at a time to the core through a req/ack/done handshake.
// Latency: source edge to irq_req is 2 cycles; ack to in_service is 1 cycle.
// Backpressure: a raised request is held, with stable id and vector, until irq_ack.
//   There is no nesting: nothing new is requested until irq_done returns the
//   block to IDLE. Edges that arrive meanwhile stay pending.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   irq_src               level interrupt lines; a 0->1 transition sets pending
//   cfg_we, cfg_wdata     enable-mask write port
//   gie                   global interrupt enable from the core
//   pc_in                 current core PC, captured on acknowledge
//   irq_ack, irq_done     core accept (while in REQ) and handler return (while in SERVICE)
//   irq_req, irq_id       request to the core and the winning source index
//   irq_vector            VEC_BASE + irq_id*VEC_STRIDE
//   pc_save, in_service   PC captured on acknowledge; high while in SERVICE
//   pending, enable       status view of the pending and enable registers
//
// Build option: define INTR_ARB_RR_EN for round-robin selection that starts after
// the last acknowledged source. Left undefined, the lowest eligible index wins.
module interrupt_arbiter #(
  parameter int          NUM_SRC    = 8,
  parameter logic [63:0] VEC_BASE   = 64'h0000_0000_0000_1000,
  parameter int          VEC_STRIDE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         irq_src,
  input  logic                       cfg_we,
  input  logic [NUM_SRC-1:0]         cfg_wdata,
  input  logic                       gie,
  input  logic [63:0]                pc_in,
  input  logic                       irq_ack,
  input  logic                       irq_done,
  output logic                       irq_req,
  output logic [$clog2(NUM_SRC)-1:0] irq_id,
  output logic [63:0]                irq_vector,
  output logic [63:0]                pc_save,
  output logic                       in_service,
  output logic [NUM_SRC-1:0]         pending,
  output logic [NUM_SRC-1:0]         enable
);

  localparam int IW    = $clog2(NUM_SRC);
  localparam int SHIFT = $clog2(VEC_STRIDE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] set_mask;
  logic [NUM_SRC-1:0] clr_mask;
  logic [IW-1:0]      win_id;
  logic               win_vld;
  logic               take;
  logic               ack_fire;

  assign elig     = pending & enable;
  assign set_mask = irq_src & ~src_q;
  assign win_vld  = |elig;
  assign take     = (state == IDLE) && gie && win_vld;
  assign ack_fire = (state == REQ) && irq_ack;

  // The clear only ever targets the source being acknowledged.
  always_comb begin
    clr_mask = '0;
    if (ack_fire) clr_mask[irq_id] = 1'b1;
  end

`ifdef INTR_ARB_RR_EN
  logic [IW-1:0] last_id;
  logic [IW-1:0] pos_idx;
  int            pos;

  // Search starts one past the last acknowledged source and wraps. Since
  // last_id+1 <= NUM_SRC, a single subtraction is enough to wrap.
  always_comb begin
    win_id  = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pos = int'(last_id) + 1 + k;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      pos_idx = IW'(pos);
      // Walking from the far end keeps the nearest candidate as the last write.
      if (elig[pos_idx]) win_id = pos_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_id <= '0;
    end else if (ack_fire) begin
      last_id <= irq_id;
    end
  end
`else
  // Fixed priority: iterate downward so the lowest eligible index is the last write.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win_id = IW'(i);
    end
  end
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state. Mask or gie changes in REQ never withdraw the request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gie && win_vld) state_nxt = REQ;
      REQ:     if (irq_ack)        state_nxt = SERVICE;
      SERVICE: if (irq_done)       state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    irq_req    = (state == REQ);
    in_service = (state == SERVICE);
  end

  // Datapath registers. A new edge beats the acknowledge clear on the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      pending <= '0;
      enable  <= '0;
      irq_id  <= '0;
      pc_save <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= (pending & ~clr_mask) | set_mask;
      if (cfg_we)   enable  <= cfg_wdata;
      if (take)     irq_id  <= win_id;
      if (ack_fire) pc_save <= pc_in;
    end
  end

  // Stride is a power of two, so the multiply is a shift of the zero-extended id.
  assign irq_vector = VEC_BASE + ({{(64 - IW){1'b0}}, irq_id} << SHIFT);

endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb_interrupt_arbiter: directed scenarios plus randomized traffic against a
//   cycle-level reference model; expectations are queued as stimulus is issued and
//   a separate monitor compares them as the DUT presents outputs.
module tb_interrupt_arbiter;

  localparam int          N      = 8;
  localparam logic [63:0] VBASE  = 64'h0000_0000_0000_1000;
  localparam int          STRIDE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_src = '0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_wdata = '0;
  logic        gie = 1'b0;
  logic [63:0] pc_in = '0;
  logic        irq_ack = 1'b0;
  logic        irq_done = 1'b0;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic [63:0] irq_vector;
  logic [63:0] pc_save;
  logic        in_service;
  logic [7:0]  pending;
  logic [7:0]  enable;

  interrupt_arbiter #(.NUM_SRC(N), .VEC_BASE(VBASE), .VEC_STRIDE(STRIDE)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .gie(gie), .pc_in(pc_in), .irq_ack(irq_ack), .irq_done(irq_done),
    .irq_req(irq_req), .irq_id(irq_id), .irq_vector(irq_vector), .pc_save(pc_save),
    .in_service(in_service), .pending(pending), .enable(enable)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        req;
    logic        svc;
    logic [2:0]  id;
    logic [63:0] vec;
    logic [63:0] pcs;
    logic [7:0]  pend;
    logic [7:0]  en;
  } st_t;

  typedef struct {
    int          id;
    logic [63:0] vec;
  } req_t;

  st_t         st_q[$];
  req_t        req_q[$];
  logic [63:0] svc_q[$];

  int          m_state = 0;  // 0 idle, 1 requesting, 2 in service
  int          m_id    = 0;
  int          m_last  = 0;
  logic [63:0] m_pcs   = '0;
  logic [7:0]  m_pend  = '0;
  logic [7:0]  m_en    = '0;
  logic [7:0]  m_prev  = '0;

  function automatic logic [63:0] vec_of(input int id);
    return VBASE + 64'(id) * 64'(STRIDE);
  endfunction

  function automatic int pick(input logic [7:0] e, input int last);
    int p;
`ifdef INTR_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      p = (last + k) % N;
      if (e[3'(p)]) return p;
    end
`else
    for (int k = 0; k < N; k++) begin
      p = k;
      if (e[3'(p)]) return p;
    end
`endif
    return 0;
  endfunction

  // Advance the model by one clock using the inputs that are about to be sampled.
  task automatic model_step();
    logic [7:0] elig;
    logic [7:0] clr;
    st_t        s;
    req_t       r;
    if (reset) begin
      m_state = 0; m_id = 0; m_last = 0; m_pcs = '0;
      m_pend = '0; m_en = '0; m_prev = '0;
    end else begin
      elig = m_pend & m_en;
      clr  = '0;
      if (m_state == 0) begin
        if (gie && elig != 0) begin
          m_id  = pick(elig, m_last);
          r.id  = m_id;
          r.vec = vec_of(m_id);
          req_q.push_back(r);
          m_state = 1;
        end
      end else if (m_state == 1) begin
        if (irq_ack) begin
          m_pcs  = pc_in;
          clr    = 8'd1 << m_id;
          m_last = m_id;
          svc_q.push_back(pc_in);
          m_state = 2;
        end
      end else begin
        if (irq_done) m_state = 0;
      end
      m_pend = (m_pend & ~clr) | (irq_src & ~m_prev);
      if (cfg_we) m_en = cfg_wdata;
      m_prev = irq_src;
    end
    s.req  = (m_state == 1);
    s.svc  = (m_state == 2);
    s.id   = 3'(m_id);
    s.vec  = vec_of(m_id);
    s.pcs  = m_pcs;
    s.pend = m_pend;
    s.en   = m_en;
    st_q.push_back(s);
  endtask

  // ---------------- monitor ----------------
  logic prev_req = 1'b0;
  logic prev_svc = 1'b0;

  initial begin
    st_t  s;
    req_t r;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("irq_req",    64'(irq_req),    64'(s.req));
        chk("in_service", 64'(in_service), 64'(s.svc));
        chk("irq_id",     64'(irq_id),     64'(s.id));
        chk("irq_vector", irq_vector,      s.vec);
        chk("pc_save",    pc_save,         s.pcs);
        chk("pending",    64'(pending),    64'(s.pend));
        chk("enable",     64'(enable),     64'(s.en));
      end
      if (irq_req === 1'b1 && !prev_req) begin
        chk("req_expected", 64'(req_q.size() != 0), 64'd1);
        if (req_q.size() != 0) begin
          r = req_q.pop_front();
          chk("req_event_id",  64'(irq_id), 64'(r.id));
          chk("req_event_vec", irq_vector,  r.vec);
        end
      end
      if (in_service === 1'b1 && !prev_svc) begin
        chk("svc_expected", 64'(svc_q.size() != 0), 64'd1);
        if (svc_q.size() != 0) chk("svc_event_pc", pc_save, svc_q.pop_front());
      end
      prev_req = (irq_req === 1'b1);
      prev_svc = (in_service === 1'b1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_src = '0; irq_ack = 1'b0; irq_done = 1'b0; cfg_we = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_en(input logic [7:0] v);
    cfg_we = 1'b1; cfg_wdata = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && irq_req !== 1'b1; i++) tick();
    chk("wait_req_timeout", 64'(irq_req), 64'd1);
  endtask

  task automatic serve(output int id, input logic [63:0] pc);
    wait_req();
    id = int'(irq_id);
    pc_in = pc; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0; irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    int id;
    int exp_q1;
    int exp_q2;
`ifdef INTR_ARB_RR_EN
    exp_q1 = 5; exp_q2 = 1;
`else
    exp_q1 = 1; exp_q2 = 5;
`endif

    // Reset state
    do_reset();
    chk("rst_irq_req",    64'(irq_req),    64'd0);
    chk("rst_in_service", 64'(in_service), 64'd0);
    chk("rst_pending",    64'(pending),    64'd0);
    chk("rst_enable",     64'(enable),     64'd0);
    chk("rst_pc_save",    pc_save,         64'd0);
    chk("rst_irq_vector", irq_vector,      VBASE);

    // Single source: request 2 cycles after the edge, vector 0x1008
    gie = 1'b1;
    set_en(8'h04);
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    chk("single_pend_set", 64'(pending[2]), 64'd1);
    chk("single_no_req_yet", 64'(irq_req), 64'd0);
    tick();
    chk("single_req", 64'(irq_req), 64'd1);
    chk("single_id",  64'(irq_id),  64'd2);
    chk("single_vec", irq_vector,   64'h1008);
    pc_in = 64'h8000_0040; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("single_pc_save", pc_save, 64'h8000_0040);
    chk("single_pend_clr", 64'(pending[2]), 64'd0);
    chk("single_in_service", 64'(in_service), 64'd1);
    chk("single_req_drop", 64'(irq_req), 64'd0);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    chk("single_done_idle", 64'(in_service), 64'd0);

    // Reset mid-handshake, then a stray ack
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    tick();
    chk("midrst_in_req", 64'(irq_req), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_req",     64'(irq_req), 64'd0);
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_enable",  64'(enable),  64'd0);
    chk("midrst_pc_save", pc_save,      64'd0);
    pc_in = 64'hdead_beef_0000_0100; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("stray_ack_svc", 64'(in_service), 64'd0);
    chk("stray_ack_pc",  pc_save,         64'd0);

    // Simultaneous edges on 1, 3, 5 from reset (both policies start at index 1)
    do_reset();
    gie = 1'b1;
    set_en(8'hff);
    irq_src = 8'b0010_1010;
    tick();
    irq_src = 8'h00;
    serve(id, 64'h100); chk("prio_a_first",  64'(id), 64'd1);
    serve(id, 64'h200); chk("prio_a_second", 64'(id), 64'd3);
    serve(id, 64'h300); chk("prio_a_third",  64'(id), 64'd5);

    // Source 3 served first, then 1 and 5 pending together
    do_reset();
    gie = 1'b1;
    set_en(8'hff);
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    serve(id, 64'h400); chk("prio_b_first", 64'(id), 64'd3);
    irq_src = 8'h22;
    tick();
    irq_src = 8'h00;
    serve(id, 64'h500); chk("prio_b_second", 64'(id), 64'(exp_q1));
    serve(id, 64'h600); chk("prio_b_third",  64'(id), 64'(exp_q2));

    // Masking keeps pending; unmasking raises the request two cycles later
    do_reset();
    gie = 1'b1;
    irq_src = 8'h40;
    tick();
    irq_src = 8'h00;
    tick();
    tick();
    chk("mask_no_req", 64'(irq_req), 64'd0);
    chk("mask_pend6",  64'(pending[6]), 64'd1);
    set_en(8'h40);
    chk("unmask_not_yet", 64'(irq_req), 64'd0);
    tick();
    chk("unmask_req", 64'(irq_req), 64'd1);
    chk("unmask_id",  64'(irq_id),  64'd6);
    serve(id, 64'h700);
    gie = 1'b0;
    irq_src = 8'h40;
    tick();
    irq_src = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    chk("gie_off_no_req", 64'(irq_req), 64'd0);
    chk("gie_off_pend6",  64'(pending[6]), 64'd1);
    gie = 1'b1;
    serve(id, 64'h800);
    chk("gie_on_id", 64'(id), 64'd6);

    // No nesting, and an edge coinciding with the ack of the same source
    do_reset();
    gie = 1'b1;
    set_en(8'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    wait_req();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    tick();
    tick();
    chk("nonest_no_req", 64'(irq_req), 64'd0);
    chk("nonest_pend0",  64'(pending[0]), 64'd1);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    chk("after_done_idle", 64'(irq_req), 64'd0);
    tick();
    chk("after_done_req", 64'(irq_req), 64'd1);
    irq_ack = 1'b1; irq_src = 8'h01;
    tick();
    irq_ack = 1'b0; irq_src = 8'h00;
    chk("set_wins_pend0", 64'(pending[0]), 64'd1);
    chk("set_wins_svc",   64'(in_service), 64'd1);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    serve(id, 64'h900);

    // Randomized traffic, including stray acks/dones and occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      irq_src   = irq_src ^ 8'($urandom & $urandom & $urandom);
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_wdata = 8'($urandom);
      gie       = ($urandom_range(0, 7) != 0);
      irq_ack   = ($urandom_range(0, 2) == 0);
      irq_done  = ($urandom_range(0, 3) == 0);
      pc_in     = {$urandom, $urandom};
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; irq_ack = 1'b0; irq_done = 1'b0; cfg_we = 1'b0;

    @(posedge clk);
    #3;
    chk("req_q_drained", 64'(req_q.size()), 64'd0);
    chk("svc_q_drained", 64'(svc_q.size()), 64'd0);
    chk("st_q_drained",  64'(st_q.size()),  64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
# interrupt_arbiter

Multi-source interrupt front end for the 64-bit single-cycle RISC-V core. It captures rising edges on up to `NUM_SRC` external interrupt lines into a pending register and applies a per-source enable mask plus a global enable. It selects one winner and runs a request/acknowledge/service handshake with the core, saving the PC and supplying a handler vector. It sits between the peripheral interrupt lines and the core's trap entry logic, and guarantees one interrupt in service at a time.

## Interface
Parameters:
- `NUM_SRC`, 8: number of interrupt sources (2..32).
- `VEC_BASE`, 64'h0000_0000_0000_1000: handler table base address.
- `VEC_STRIDE`, 4: byte distance between vector entries (power of two).

Ports:
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_src`  in  NUM_SRC  level interrupt lines; a 0→1 transition sets pending.
- `cfg_we`  in  1  write strobe for the enable mask.
- `cfg_wdata`  in  NUM_SRC  new enable mask.
- `gie`  in  1  global interrupt enable from the core.
- `pc_in`  in  64  current core PC.
- `irq_ack`  in  1  core accepts the request; valid only while `irq_req`=1.
- `irq_done`  in  1  handler return (mret); valid only in SERVICE.
- `irq_req`  out  1  interrupt request to the core.
- `irq_id`  out  $clog2(NUM_SRC)  winning source index.
- `irq_vector`  out  64  `VEC_BASE + irq_id*VEC_STRIDE`.
- `pc_save`  out  64  PC captured on acknowledge.
- `in_service`  out  1  high while in SERVICE.
- `pending`  out  NUM_SRC  pending register, visible for status reads.
- `enable`  out  NUM_SRC  enable mask register.

## Operation
- **Edge capture.** `src_q` registers `irq_src`. `pending[i]` is set when `irq_src[i] & ~src_q[i]`. It is cleared only when source `i` is acknowledged. If a set and a clear hit the same bit in the same cycle, set wins.
- **Eligibility.** `elig = pending & enable`. Selection happens only when `gie`=1.
- **Mask register.** `enable` loads `cfg_wdata` on `cfg_we`. Masking a source never clears its pending bit.
- **Winner selection.** Fixed priority: the lowest eligible index wins (see Configuration for the alternative).
- **FSM states:** IDLE, REQ, SERVICE.
  - **IDLE:** if `gie` and `|elig`, latch the winner into `irq_id` and go to REQ. `irq_done` is ignored here.
  - **REQ:** `irq_req`=1. `irq_id` and `irq_vector` are stable; changes to the mask or `gie` do not withdraw the request. On `irq_ack`:
    - `pc_save <= pc_in`
    - clear `pending[irq_id]`
    - go to SERVICE.
  - **SERVICE:** `in_service`=1; no new request is raised (no nesting). On `irq_done`, go to IDLE.
- **Reset values.** Reset forces IDLE from any state, including mid-handshake, and sets:
  - `pending`=0, `enable`=0, `src_q`=0
  - `irq_req`=0, `irq_id`=0, `pc_save`=0, `in_service`=0
  - `irq_vector`=`VEC_BASE`.
- **Vector arithmetic.** The vector is computed in 64 bits: `irq_id` is zero-extended and shifted by log2(`VEC_STRIDE`). There is no overflow handling.

## Timing
- Edge on `irq_src[i]` sampled at edge t → `pending[i]`=1 after edge t.
- Eligible in IDLE during cycle t+1 → `irq_req`=1 after edge t+1. Source-to-request latency is 2 cycles.
- `irq_ack` sampled high at edge a → `irq_req`=0, `in_service`=1, `pc_save` valid, and the pending bit is cleared, all after edge a.
- `irq_ack` and `irq_req` are allowed in the same cycle, so acknowledgement can complete in 1 cycle.
- `irq_done` at edge d → IDLE after d. A new request asserts after edge d+1 at the earliest.
- A source that re-edges while in SERVICE stays pending and is served after return.
- `irq_ack` outside REQ and `irq_done` outside SERVICE have no effect.

## Configuration
- **`INTR_ARB_RR_EN`** defined: round-robin selection.
  - A `last_id` register (reset 0) is updated on each acknowledge.
  - The search starts at `last_id+1` and wraps modulo `NUM_SRC`.
  - After reset the first search starts at index 1, so index 0 has the lowest priority for the first arbitration only.
- **`INTR_ARB_RR_EN`** undefined: fixed lowest-index priority and no `last_id` register. All other behaviour is identical.

## Test plan
- **Reset mid-handshake.** Drive a request to REQ, then assert `reset` for 1 cycle → `irq_req`=0, `pending`=0, `enable`=0, `pc_save`=0, state IDLE; a later `irq_ack` is ignored.
- **Single source.** `enable`=8'h04, `gie`=1, rising edge on `irq_src[2]`, `pc_in`=64'h8000_0040:
  - `irq_req` rises 2 cycles after the edge, with `irq_id`=2 and `irq_vector`=64'h1008.
  - After the ack: `pc_save`=64'h8000_0040 and `pending[2]`=0.
- **Simultaneous sources, fixed priority.** Edges on sources 1, 3 and 5 in the same cycle, all enabled → served in order 1, 3, 5, each after the previous `irq_done`.
- **Simultaneous sources, round-robin.** With `INTR_ARB_RR_EN`: source 3 served, then sources 1 and 5 pending → 5 is served before 1.
- **Masking and gating.**
  - Source 6 edges while `enable[6]`=0 → no request and `pending[6]`=1. Writing `enable`=8'h40 → request with `irq_id`=6 two cycles later.
  - With `gie`=0, nothing is requested.
- **No nesting, set-wins.** Source 0 edges while in SERVICE → no `irq_req` until `irq_done`. A same-cycle ack of source 0 plus a new edge on source 0 leaves `pending[0]`=1.
